// File: rtl/mac_array_unit.sv
// Multi-precision multiply-accumulate array for the eFPGA math block.
// Runs 1x32, 2x16, 4x8 and (optionally) 8x4-bit MAC lanes in parallel, each
// with a shift / round / saturate output stage.
// Optional build macro MAC_ACC_GUARD_EN: adds 8 guard bits to every accumulator.

module mac_array_lane #(
  parameter int unsigned W  = 8,
  parameter int unsigned SW = $clog2(W) + 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [W-1:0]  oper,
  input  logic [W-1:0]  coef,
  input  logic          en,
  input  logic          clear,
  input  logic          rnd,
  input  logic          sat,
  input  logic          tc,
  input  logic [SW-1:0] sel,
  output logic [W-1:0]  result
);
`ifdef MAC_ACC_GUARD_EN
  localparam int unsigned AW = 2 * W + 8;
`else
  localparam int unsigned AW = 2 * W;
`endif

  logic [AW-1:0]        acc;
  logic [AW-1:0]        oper_x;
  logic [AW-1:0]        coef_x;
  logic [AW-1:0]        prod;
  logic [AW:0]          acc_x;
  logic [AW:0]          rnd_add;
  logic [AW:0]          rounded;
  logic [AW:0]          sh_l;
  logic signed [AW:0]   sh_a;
  logic [AW:0]          shifted;

  // Operands extended to accumulator width; low AW bits of the product are exact
  always_comb begin
    oper_x = tc ? {{(AW-W){oper[W-1]}}, oper} : {{(AW-W){1'b0}}, oper};
    coef_x = tc ? {{(AW-W){coef[W-1]}}, coef} : {{(AW-W){1'b0}}, coef};
    prod   = oper_x * coef_x;
  end

  // Accumulator: load or accumulate when enabled, async clear on reset
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc <= '0;
    end else if (en) begin
      acc <= clear ? prod : acc + prod;
    end
  end

  // Round half-up in one extra bit, then shift arithmetic or logical
  always_comb begin
    acc_x   = tc ? {acc[AW-1], acc} : {1'b0, acc};
    rnd_add = (rnd && (sel != '0)) ? ((AW+1)'(1) << (sel - SW'(1))) : '0;
    rounded = acc_x + rnd_add;
    sh_a    = $signed(rounded) >>> sel;
    sh_l    = rounded >> sel;
    shifted = tc ? sh_a : sh_l;
  end

  // Clamp to lane range or truncate to the low W bits
  always_comb begin
    result = shifted[W-1:0];
    if (sat) begin
      if (tc) begin
        if (shifted[AW:W-1] != {(AW-W+2){shifted[AW]}}) begin
          result = shifted[AW] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
      end else if (|shifted[AW:W]) begin
        result = '1;
      end
    end
  end
endmodule

module mac_array_unit #(
  parameter int unsigned MU     = 0,
  parameter int unsigned BLOCK  = 0,
  parameter int unsigned USE_BW = 0
) (
  input  logic        EFPGA2MATHB_CLK,
  input  logic        acc_ff_rstn,
  input  logic [31:0] MAC_OPER_DATA,
  input  logic [31:0] MAC_COEF_DATA,
  input  logic        EFPGA_MATHB_CLK_EN,
  input  logic        MAC_ACC_CLEAR,
  input  logic        MAC_ACC_RND,
  input  logic        MAC_ACC_SAT,
  input  logic [5:0]  MAC_OUT_SEL,
  input  logic        MAC_TC,
  output logic [31:0] MAC0_OUT,
  output logic [15:0] MAC1_OUT,
  output logic [15:0] MAC2_OUT,
  output logic [7:0]  MAC3_OUT,
  output logic [7:0]  MAC4_OUT,
  output logic [7:0]  MAC5_OUT,
  output logic [7:0]  MAC6_OUT,
  output logic [3:0]  MAC_4_0_OUT,
  output logic [3:0]  MAC_4_1_OUT,
  output logic [3:0]  MAC_4_2_OUT,
  output logic [3:0]  MAC_4_3_OUT,
  output logic [3:0]  MAC_4_4_OUT,
  output logic [3:0]  MAC_4_5_OUT,
  output logic [3:0]  MAC_4_6_OUT,
  output logic [3:0]  MAC_4_7_OUT
);
  logic [15:0] r16 [2];
  logic [7:0]  r8  [4];
  logic [3:0]  r4  [8];

  // Identification parameters only; folded here so they are referenced
  logic unused_id;
  assign unused_id = ^{8'(MU), 8'(BLOCK)};

  // Full-width 32-bit lane
  mac_array_lane #(.W(32), .SW(6)) u_lane32 (
    .clk(EFPGA2MATHB_CLK), .rstn(acc_ff_rstn),
    .oper(MAC_OPER_DATA), .coef(MAC_COEF_DATA),
    .en(EFPGA_MATHB_CLK_EN), .clear(MAC_ACC_CLEAR), .rnd(MAC_ACC_RND),
    .sat(MAC_ACC_SAT), .tc(MAC_TC), .sel(MAC_OUT_SEL), .result(MAC0_OUT)
  );

  // 16-bit lanes, index 0 on the upper half
  for (genvar i = 0; i < 2; i++) begin : g_l16
    mac_array_lane #(.W(16), .SW(5)) u_lane (
      .clk(EFPGA2MATHB_CLK), .rstn(acc_ff_rstn),
      .oper(MAC_OPER_DATA[31-16*i -: 16]), .coef(MAC_COEF_DATA[31-16*i -: 16]),
      .en(EFPGA_MATHB_CLK_EN), .clear(MAC_ACC_CLEAR), .rnd(MAC_ACC_RND),
      .sat(MAC_ACC_SAT), .tc(MAC_TC), .sel(MAC_OUT_SEL[4:0]), .result(r16[i])
    );
  end

  // 8-bit lanes, index 0 on the top byte
  for (genvar i = 0; i < 4; i++) begin : g_l8
    mac_array_lane #(.W(8), .SW(4)) u_lane (
      .clk(EFPGA2MATHB_CLK), .rstn(acc_ff_rstn),
      .oper(MAC_OPER_DATA[31-8*i -: 8]), .coef(MAC_COEF_DATA[31-8*i -: 8]),
      .en(EFPGA_MATHB_CLK_EN), .clear(MAC_ACC_CLEAR), .rnd(MAC_ACC_RND),
      .sat(MAC_ACC_SAT), .tc(MAC_TC), .sel(MAC_OUT_SEL[3:0]), .result(r8[i])
    );
  end

  // 4-bit lanes, built only when requested
  if (USE_BW != 0) begin : g_bw
    for (genvar k = 0; k < 8; k++) begin : g_l4
      mac_array_lane #(.W(4), .SW(3)) u_lane (
        .clk(EFPGA2MATHB_CLK), .rstn(acc_ff_rstn),
        .oper(MAC_OPER_DATA[4*k+3 -: 4]), .coef(MAC_COEF_DATA[4*k+3 -: 4]),
        .en(EFPGA_MATHB_CLK_EN), .clear(MAC_ACC_CLEAR), .rnd(MAC_ACC_RND),
        .sat(MAC_ACC_SAT), .tc(MAC_TC), .sel(MAC_OUT_SEL[2:0]), .result(r4[k])
      );
    end
  end else begin : g_no_bw
    for (genvar k = 0; k < 8; k++) begin : g_tie
      assign r4[k] = 4'h0;
    end
  end

  // Map lane results onto the named output ports
  always_comb begin
    MAC1_OUT    = r16[0];
    MAC2_OUT    = r16[1];
    MAC3_OUT    = r8[0];
    MAC4_OUT    = r8[1];
    MAC5_OUT    = r8[2];
    MAC6_OUT    = r8[3];
    MAC_4_0_OUT = r4[0];
    MAC_4_1_OUT = r4[1];
    MAC_4_2_OUT = r4[2];
    MAC_4_3_OUT = r4[3];
    MAC_4_4_OUT = r4[4];
    MAC_4_5_OUT = r4[5];
    MAC_4_6_OUT = r4[6];
    MAC_4_7_OUT = r4[7];
  end
endmodule

// File: tb/tb_mac_array_unit.sv
// Directed bench for mac_array_unit: one instance with 4-bit lanes, one without.

module tb_mac_array_unit;
  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] oper, coef;
  logic        en, clear, rnd, sat, tc;
  logic [5:0]  sel;

  logic [31:0] mac0;
  logic [15:0] mac1, mac2;
  logic [7:0]  mac3, mac4, mac5, mac6;
  logic [3:0]  m4 [8];
  logic [31:0] nb_mac0;
  logic [15:0] nb_mac1, nb_mac2;
  logic [7:0]  nb_mac3, nb_mac4, nb_mac5, nb_mac6;
  logic [3:0]  nb4 [8];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mac_array_unit #(.MU(0), .BLOCK(0), .USE_BW(1)) dut (
    .EFPGA2MATHB_CLK(clk), .acc_ff_rstn(rstn),
    .MAC_OPER_DATA(oper), .MAC_COEF_DATA(coef),
    .EFPGA_MATHB_CLK_EN(en), .MAC_ACC_CLEAR(clear), .MAC_ACC_RND(rnd),
    .MAC_ACC_SAT(sat), .MAC_OUT_SEL(sel), .MAC_TC(tc),
    .MAC0_OUT(mac0), .MAC1_OUT(mac1), .MAC2_OUT(mac2),
    .MAC3_OUT(mac3), .MAC4_OUT(mac4), .MAC5_OUT(mac5), .MAC6_OUT(mac6),
    .MAC_4_0_OUT(m4[0]), .MAC_4_1_OUT(m4[1]), .MAC_4_2_OUT(m4[2]), .MAC_4_3_OUT(m4[3]),
    .MAC_4_4_OUT(m4[4]), .MAC_4_5_OUT(m4[5]), .MAC_4_6_OUT(m4[6]), .MAC_4_7_OUT(m4[7])
  );

  mac_array_unit #(.MU(1), .BLOCK(2), .USE_BW(0)) dut_nobw (
    .EFPGA2MATHB_CLK(clk), .acc_ff_rstn(rstn),
    .MAC_OPER_DATA(oper), .MAC_COEF_DATA(coef),
    .EFPGA_MATHB_CLK_EN(en), .MAC_ACC_CLEAR(clear), .MAC_ACC_RND(rnd),
    .MAC_ACC_SAT(sat), .MAC_OUT_SEL(sel), .MAC_TC(tc),
    .MAC0_OUT(nb_mac0), .MAC1_OUT(nb_mac1), .MAC2_OUT(nb_mac2),
    .MAC3_OUT(nb_mac3), .MAC4_OUT(nb_mac4), .MAC5_OUT(nb_mac5), .MAC6_OUT(nb_mac6),
    .MAC_4_0_OUT(nb4[0]), .MAC_4_1_OUT(nb4[1]), .MAC_4_2_OUT(nb4[2]), .MAC_4_3_OUT(nb4[3]),
    .MAC_4_4_OUT(nb4[4]), .MAC_4_5_OUT(nb4[5]), .MAC_4_6_OUT(nb4[6]), .MAC_4_7_OUT(nb4[7])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0; oper = '0; coef = '0; en = 1'b0; clear = 1'b0;
    rnd = 1'b0; sat = 1'b0; tc = 1'b0; sel = '0;
    #2;
    chk("reset_mac0", mac0, 32'd0);
    chk("reset_mac6", 32'(mac6), 32'd0);
    chk("reset_m4_0", 32'(m4[0]), 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    // 32-bit unsigned accumulate
    en = 1'b1; clear = 1'b1; oper = 32'd3; coef = 32'd5;
    tick();
    chk("u32_load", mac0, 32'd15);
    chk("u8_load_mac6", 32'(mac6), 32'h0F);
    clear = 1'b0;
    tick();
    tick();
    chk("u32_acc", mac0, 32'd45);
    chk("u8_acc_mac6", 32'(mac6), 32'h2D);

    // Enable low: new data and clear are ignored
    en = 1'b0; clear = 1'b1; oper = 32'hFFFF_FFFF; coef = 32'h1234_5678;
    tick();
    tick();
    tick();
    chk("hold_mac0", mac0, 32'd45);
    chk("hold_mac6", 32'(mac6), 32'h2D);
    chk("hold_mac1", 32'(mac1), 32'd0);

    // Reset pulse between edges clears outputs immediately
    #2;
    rstn = 1'b0;
    #1;
    chk("async_rst_mac0", mac0, 32'd0);
    chk("async_rst_mac6", 32'(mac6), 32'd0);
    rstn = 1'b1;

    // 8-bit signed with saturation
    @(negedge clk);
    en = 1'b1; clear = 1'b1; tc = 1'b1; sat = 1'b1; sel = '0; rnd = 1'b0;
    oper = 32'h02FF_7F01; coef = 32'h0302_0280;
    tick();
    chk("s8_mac3", 32'(mac3), 32'h06);
    chk("s8_mac4", 32'(mac4), 32'hFE);
    chk("s8_mac5_sat", 32'(mac5), 32'h7F);
    chk("s8_mac6", 32'(mac6), 32'h80);
    sat = 1'b0;
    #1;
    chk("s8_mac5_nosat", 32'(mac5), 32'hFE);

    // 16-bit shift and round, unsigned
    tc = 1'b0; sat = 1'b0; oper = 32'h0001_0018; coef = 32'h0001_0001;
    clear = 1'b1; sel = 6'd4; rnd = 1'b1;
    tick();
    chk("u16_rnd_mac2", 32'(mac2), 32'd2);
    chk("u16_rnd_mac1", 32'(mac1), 32'd0);
    chk("u32_rnd_mac0", mac0, 32'h1001_9002);
    rnd = 1'b0;
    #1;
    chk("u16_trunc_mac2", 32'(mac2), 32'd1);
    chk("u32_trunc_mac0", mac0, 32'h1001_9001);

    // 4-bit lanes, signed
    tc = 1'b1; sat = 1'b0; sel = '0; rnd = 1'b0; clear = 1'b1;
    oper = 32'h7777_7777; coef = 32'h1111_1111;
    tick();
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("bw_m4_%0d", k), 32'(m4[k]), 32'd7);
      chk($sformatf("nobw_m4_%0d", k), 32'(nb4[k]), 32'd0);
    end
    chk("s8_wrap_mac3", 32'(mac3), 32'hE7);
    sat = 1'b1;
    #1;
    chk("s8_sat_mac3", 32'(mac3), 32'h7F);
    chk("nobw_s8_sat_mac3", 32'(nb_mac3), 32'h7F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mac_array_unit.md
Name: mac_array_unit

Overview:
- Multi-precision multiply-accumulate array inside the eFPGA math block.
- Multiplies a 32-bit operand word by a 32-bit coefficient word and accumulates the product. All four precisions run concurrently:
  - 1x32-bit
  - 2x16-bit
  - 4x8-bit
  - 8x4-bit lanes
- Each lane's accumulator is shifted, rounded and saturated to lane width. The parent block selects one precision set and registers it.

Parameters:
- MU, 0, math-unit index; identification only, no functional effect.
- BLOCK, 0, block index within math unit; identification only.
- USE_BW, 0, 1 = build the 8x4-bit lanes; 0 = 4-bit lanes omitted, MAC_4_k_OUT tied to 0.

Ports:
- EFPGA2MATHB_CLK  in  1  accumulator clock, rising edge.
- acc_ff_rstn  in  1  asynchronous active-low reset of all accumulators.
- MAC_OPER_DATA  in  32  operand word.
- MAC_COEF_DATA  in  32  coefficient word.
- EFPGA_MATHB_CLK_EN  in  1  accumulator update enable.
- MAC_ACC_CLEAR  in  1  load product instead of accumulate.
- MAC_ACC_RND  in  1  round-half-up before right shift.
- MAC_ACC_SAT  in  1  saturate result to lane width.
- MAC_OUT_SEL  in  6  right-shift amount applied to accumulators.
- MAC_TC  in  1  1 = two's-complement operands/results; 0 = unsigned.
- MAC0_OUT  out  32  32-bit lane result.
- MAC1_OUT, MAC2_OUT  out  16 each  16-bit lanes on operand bits [31:16] and [15:0].
- MAC3_OUT..MAC6_OUT  out  8 each  8-bit lanes on bits [31:24], [23:16], [15:8], [7:0].
- MAC_4_0_OUT..MAC_4_7_OUT  out  4 each  4-bit lane k on bits [4k+3:4k].

Behaviour:
- Lane operation:
  - Lane width W in {32,16,8,4}.
  - Product = oper_lane x coef_lane, 2W bits, signed when MAC_TC=1, else unsigned.
  - Accumulator width 2W; wraps modulo 2^(2W).
- Accumulator update at rising EFPGA2MATHB_CLK, only when EFPGA_MATHB_CLK_EN=1:
  - CLEAR=1: acc <= product.
  - CLEAR=0: acc <= acc + product.
  - EN=0: hold; CLEAR is ignored.
- Reset: acc_ff_rstn=0 clears all accumulators to 0 asynchronously; all outputs then read 0.
- Output path is combinational from the accumulators. A product sampled at edge N is visible at the outputs after edge N.
- Shift amount s per lane width:
  - 32-bit: MAC_OUT_SEL[5:0]
  - 16-bit: [4:0]
  - 8-bit: [3:0]
  - 4-bit: [2:0]
- Shift type: arithmetic when TC=1, logical when TC=0.
- Rounding: if RND=1 and s>0, add 2^(s-1) to acc (in 2W+1 bits) before the shift. If s=0, no rounding.
- Saturation:
  - SAT=1: clamp the shifted value to [-2^(W-1), 2^(W-1)-1] when TC=1, or [0, 2^W-1] when TC=0.
  - SAT=0: output the low W bits.
- MAC_TC, RND, SAT and MAC_OUT_SEL take effect combinationally; changing them does not alter stored accumulators.
- Simultaneous reset and clock edge: reset wins.

Optional Feature:
- Macro MAC_ACC_GUARD_EN.
- Defined: every accumulator is widened to 2W+8 bits (8 guard bits, sign-extended when TC=1). This prevents wrap for up to 256 full-scale accumulations. Shift, round and saturate operate on the widened value.
- Not defined: accumulators are 2W bits and wrap as stated above.

Test Plan:
- Reset:
  - Load nonzero accumulators, then pulse acc_ff_rstn=0 mid-operation.
  - All outputs read 0 immediately, with no clock edge.
- 32-bit unsigned accumulate:
  - Setup: TC=0, SEL=0, EN=1.
  - CLEAR=1 with oper=3, coef=5: MAC0_OUT=15.
  - Two edges with CLEAR=0: MAC0_OUT=45.
- 8-bit signed with saturation:
  - Setup: TC=1, SAT=1, CLEAR=1, oper=0x02FF7F01, coef=0x03020280.
  - Expect MAC3=0x06, MAC4=0xFE, MAC5=0x7F (saturated from 254), MAC6=0x80.
  - With SAT=0: MAC5=0xFE.
- 16-bit shift/round:
  - Setup: TC=0, oper=0x00010018, coef=0x00010001, CLEAR=1, SEL=4.
  - RND=1: MAC2=2, MAC1=0.
  - RND=0: MAC2=1.
- Enable hold:
  - After an accumulation, set EN=0 and apply new nonzero data with CLEAR=1 for 3 edges.
  - All outputs unchanged.
- 4-bit lanes:
  - Setup: USE_BW=1, TC=1, oper=0x77777777, coef=0x11111111, CLEAR=1, SEL=0.
  - Every MAC_4_k_OUT=7.
  - With USE_BW=0, every MAC_4_k_OUT=0.
